cnt_cmd_sequencer: RTL

Command-driven stimulus sequencer that sits directly upstream of the dual event counter and drives its `En`/`Slt` inputs. A producer pushes burst commands through a valid/ready port into a small FIFO. Each command names a counter select, a burst length and an idle gap. The sequencer replays commands in order as exact runs of enable cycles, so the counter's `Output0` and `Output1` advance by deterministic amounts.

---
 rtl/cnt_cmd_sequencer_if.sv | 15 +
 rtl/cnt_cmd_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cnt_cmd_sequencer_if.sv
// Command port of the burst sequencer: valid/ready handshake carrying {slt, len, gap}.
// The producer side uses the master modport and the sequencer uses the slave modport.
interface cnt_cmd_sequencer_if #(
  parameter int LEN_W = 16,
  parameter int GAP_W = 8
);
  logic             CmdValid;
  logic             CmdReady;
  logic             CmdSlt;
  logic [LEN_W-1:0] CmdLen;
  logic [GAP_W-1:0] CmdGap;

  modport master (output CmdValid, output CmdSlt, output CmdLen, output CmdGap, input CmdReady);
  modport slave  (input CmdValid, input CmdSlt, input CmdLen, input CmdGap, output CmdReady);
endinterface

// File: rtl/cnt_cmd_sequencer.sv
// Replays queued burst commands as exact runs of counter enables followed by idle gaps.
// Commands are buffered in a small FIFO, and Done pulses once for each completed command.
module cnt_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16,
  parameter int GAP_W = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  cnt_cmd_sequencer_if.slave  cmd,
  input  logic                Pause,
  output logic                En,
  output logic                Slt,
  output logic                Busy,
  output logic                Done,
  output logic [7:0]          CmdCount
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_mem_slt [DEPTH];
  logic [LEN_W-1:0] r_mem_len [DEPTH];
  logic [GAP_W-1:0] r_mem_gap [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic             r_slt_q;
  logic [LEN_W-1:0] r_rem;
  logic [GAP_W-1:0] r_gap_q;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_done;
  logic [7:0]       r_cmd_count;

  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_complete;
  logic             w_head_slt;
  logic [LEN_W-1:0] w_head_len;
  logic [GAP_W-1:0] w_head_gap;

  assign w_ready    = (r_count != FULL_CNT);
  assign w_push     = cmd.CmdValid && w_ready;
  assign w_pop      = (r_state == ST_IDLE) && (r_count != '0);
  assign w_head_slt = r_mem_slt[r_rptr];
  assign w_head_len = r_mem_len[r_rptr];
  assign w_head_gap = r_mem_gap[r_rptr];

  // FIFO storage holds no control state, so it is not reset.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem_slt[r_wptr] <= cmd.CmdSlt;
      r_mem_len[r_wptr] <= cmd.CmdLen;
      r_mem_gap[r_wptr] <= cmd.CmdGap;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          if (w_head_len != '0) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_complete  = 1'b1;
            w_state_nxt = (w_head_gap != '0) ? ST_GAP : ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!Pause && (r_rem <= LEN_W'(1))) begin
          w_complete  = 1'b1;
          w_state_nxt = (r_gap_q != '0) ? ST_GAP : ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt <= GAP_W'(1)) w_state_nxt = ST_IDLE;
        else                        w_state_nxt = ST_GAP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // gap_cnt is preloaded on every pop and reloaded at the end of a burst.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_slt_q     <= 1'b0;
      r_rem       <= '0;
      r_gap_q     <= '0;
      r_gap_cnt   <= '0;
      r_done      <= 1'b0;
      r_cmd_count <= 8'd0;
    end else begin
      r_done <= w_complete;
      if (w_complete) r_cmd_count <= r_cmd_count + 8'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_slt_q   <= w_head_slt;
            r_rem     <= w_head_len;
            r_gap_q   <= w_head_gap;
            r_gap_cnt <= w_head_gap;
          end
        end
        ST_RUN: begin
          if (!Pause) begin
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem <= LEN_W'(1)) r_gap_cnt <= r_gap_q;
          end
        end
        ST_GAP:  r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        default: r_gap_cnt <= '0;
      endcase
    end
  end

  assign cmd.CmdReady = w_ready;
  assign En           = (r_state == ST_RUN) && !Pause;
  assign Slt          = (r_state == ST_RUN) && r_slt_q;
  assign Busy         = (r_state != ST_IDLE) || (r_count != '0);
  assign Done         = r_done;
  assign CmdCount     = r_cmd_count;
endmodule
